// File: rtl/ppu_pkg.sv
// Shared PPU definitions: OAM geometry, sprite buffer entry layout and
// the OAM scanner state encoding.
package ppu_pkg;

    localparam int NUM_OAM_ENTRIES = 40;
    localparam int MAX_SPRITES     = 10;
    localparam logic [15:0] OAM_BASE = 16'hFE00;

    // Sized forms of the limits for direct comparison against counters
    localparam logic [5:0] LAST_OAM_IDX    = 6'(NUM_OAM_ENTRIES - 1);
    localparam logic [3:0] MAX_SPRITES_CNT = 4'(MAX_SPRITES);

    // One sprite buffer slot as consumed by the pixel FIFO / sprite fetcher
    typedef struct packed {
        logic [7:0] x;
        logic [5:0] oam_index;
        logic [3:0] row;
    } sprite_entry_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_Y  = 3'd1,
        WAIT_Y = 3'd2,
        REQ_X  = 3'd3,
        WAIT_X = 3'd4,
        NEXT   = 3'd5,
        DONE   = 3'd6
    } scan_state_t;

    // Address of the Y byte of an OAM entry; the X byte follows it
    function automatic logic [15:0] oam_y_addr(input logic [5:0] idx);
        return OAM_BASE + {8'h00, idx, 2'b00};
    endfunction

endpackage

// File: rtl/oam_y_match.sv
// Decides whether a sprite with OAM Y byte 'y' covers scanline 'ly' and,
// if so, which sprite row lands on that line. Purely combinational so the
// sprite fetcher can reuse it to recompute rows.
module oam_y_match (
    input  logic [7:0] ly,
    input  logic [7:0] y,
    input  logic       tall,
    output logic       hit,
    output logic [3:0] row
);

    logic [8:0] line_s;
    logic [8:0] dist_s;
    logic [8:0] height_s;

    // OAM Y is offset by 16: a sprite covers lines [Y-16, Y-16+height)
    always_comb begin
        line_s   = {1'b0, ly} + 9'd16;
        dist_s   = line_s - {1'b0, y};
        height_s = tall ? 9'd16 : 9'd8;
        hit      = (line_s >= {1'b0, y}) && (dist_s < height_s);
        row      = dist_s[3:0];
    end

endmodule

// File: rtl/oam_scanner.sv
// PPU mode-2 OAM scanner: walks all OAM entries for the current line and
// collects up to MAX_SPRITES overlapping sprites, lowest OAM index first.
module oam_scanner
    import ppu_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        tclk_in,
    input  logic        start_in,
    input  logic [7:0]  LY_in,
    input  logic [7:0]  LCDC_in,
    output logic [15:0] addr_out,
    output logic        addr_valid_out,
    input  logic [7:0]  data_in,
    input  logic        data_valid_in,
    output logic [17:0] sprite_buffer_out [MAX_SPRITES-1:0],
    output logic [3:0]  sprite_count_out,
    output logic        busy_out,
    output logic        done_out
);

    scan_state_t   state_r;
    scan_state_t   state_next_s;

    logic [7:0]    ly_r;
    logic          tall_r;
    logic [5:0]    idx_r;
    logic [3:0]    count_r;
    logic [3:0]    row_r;
    logic [15:0]   addr_r;
    logic          addr_valid_r;
    logic          busy_r;
    logic          done_r;
    sprite_entry_t buffer_r [MAX_SPRITES];

    logic          hit_s;
    logic [3:0]    row_s;
    logic          scan_end_s;
    sprite_entry_t new_entry_s;

    logic          start_s;
    logic          issue_y_s;
    logic          take_y_s;
    logic          issue_x_s;
    logic          take_x_s;
    logic          advance_s;
    logic          finish_s;
    logic          lcdc_unused_s;

    // Only the sprite-height bit of LCDC matters here
    assign lcdc_unused_s = ^{LCDC_in[7:3], LCDC_in[1:0]};

    oam_y_match u_y_match (
        .ly   (ly_r),
        .y    (data_in),
        .tall (tall_r),
        .hit  (hit_s),
        .row  (row_s)
    );

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Stop after the last OAM entry or as soon as the buffer is full
    always_comb begin
        scan_end_s = (count_r == MAX_SPRITES_CNT) || (idx_r == LAST_OAM_IDX);
    end

    // Next-state logic; requests and start wait for a T-cycle, responses do not
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_in && tclk_in) state_next_s = REQ_Y;
                else                     state_next_s = IDLE;
            end
            REQ_Y: begin
                if (tclk_in) state_next_s = WAIT_Y;
                else         state_next_s = REQ_Y;
            end
            WAIT_Y: begin
                if (data_valid_in) state_next_s = hit_s ? REQ_X : NEXT;
                else               state_next_s = WAIT_Y;
            end
            REQ_X: begin
                if (tclk_in) state_next_s = WAIT_X;
                else         state_next_s = REQ_X;
            end
            WAIT_X: begin
                if (data_valid_in) state_next_s = NEXT;
                else               state_next_s = WAIT_X;
            end
            NEXT: begin
                if (scan_end_s) state_next_s = DONE;
                else            state_next_s = REQ_Y;
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Decode the current state into one-cycle datapath strobes
    always_comb begin
        start_s   = 1'b0;
        issue_y_s = 1'b0;
        take_y_s  = 1'b0;
        issue_x_s = 1'b0;
        take_x_s  = 1'b0;
        advance_s = 1'b0;
        finish_s  = 1'b0;
        case (state_r)
            IDLE:    start_s   = start_in && tclk_in;
            REQ_Y:   issue_y_s = tclk_in;
            WAIT_Y:  take_y_s  = data_valid_in;
            REQ_X:   issue_x_s = tclk_in;
            WAIT_X:  take_x_s  = data_valid_in;
            NEXT: begin
                advance_s = !scan_end_s;
                finish_s  = scan_end_s;
            end
            DONE:    start_s   = 1'b0;
            default: start_s   = 1'b0;
        endcase
    end

    // Slot written on an X response
    always_comb begin
        new_entry_s = '{x: data_in, oam_index: idx_r, row: row_r};
    end

    // Datapath: line latch, memory request, index/count and sprite buffer
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ly_r         <= 8'h00;
            tall_r       <= 1'b0;
            idx_r        <= 6'd0;
            count_r      <= 4'd0;
            row_r        <= 4'd0;
            addr_r       <= 16'h0000;
            addr_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            for (int i = 0; i < MAX_SPRITES; i++) begin
                buffer_r[i] <= '0;
            end
        end else begin
            if (start_s) begin
                ly_r    <= LY_in;
                tall_r  <= LCDC_in[2];
                idx_r   <= 6'd0;
                count_r <= 4'd0;
                busy_r  <= 1'b1;
                for (int i = 0; i < MAX_SPRITES; i++) begin
                    buffer_r[i] <= '0;
                end
            end
            if (issue_y_s) begin
                addr_r       <= oam_y_addr(idx_r);
                addr_valid_r <= 1'b1;
            end
            if (issue_x_s) begin
                addr_r       <= oam_y_addr(idx_r) + 16'd1;
                addr_valid_r <= 1'b1;
            end
            if (take_y_s) begin
                addr_valid_r <= 1'b0;
                if (hit_s) row_r <= row_s;
            end
            if (take_x_s) begin
                addr_valid_r <= 1'b0;
                count_r      <= count_r + 4'd1;
                for (int i = 0; i < MAX_SPRITES; i++) begin
                    if (count_r == 4'(i)) buffer_r[i] <= new_entry_s;
                end
            end
            if (advance_s) begin
                idx_r <= idx_r + 6'd1;
            end
            if (finish_s) begin
                busy_r <= 1'b0;
            end
            done_r <= finish_s;
        end
    end

    // Drive the flat buffer view seen by the consumers
    always_comb begin
        for (int i = 0; i < MAX_SPRITES; i++) begin
            sprite_buffer_out[i] = buffer_r[i];
        end
    end

    assign addr_out         = addr_r;
    assign addr_valid_out   = addr_valid_r;
    assign sprite_count_out = count_r;
    assign busy_out         = busy_r;
    assign done_out         = done_r;

endmodule

// File: doc/oam_scanner.md
Name: oam_scanner

Overview:
- PPU mode-2 stage, directly upstream of the pixel FIFO.
- Started once per visible scanline; walks the 40 OAM entries, reading each entry's Y byte and, on a hit, its X byte.
- Collects up to 10 sprites overlapping the current line into the sprite buffer that the pixel FIFO and sprite fetcher consume.
- Memory access uses the same addr/valid/data/valid handshake as the fetchers.

Parameters:
- NUM_OAM_ENTRIES, 40, OAM entries scanned per line.
- MAX_SPRITES, 10, sprite buffer slots.
- OAM_BASE, 16'hFE00, address of OAM entry 0.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset; synchronous, active-high.
- tclk_in  input  1  T-cycle enable; FSM request issue and start sampling only on clk_in edges with tclk_in=1.
- start_in  input  1  begin scan for the line in LY_in.
- LY_in  input  8  current scanline; latched at start.
- LCDC_in  input  8  only bit 2 used (0 = 8-px, 1 = 16-px sprites); latched at start.
- addr_out  output  16  OAM byte address.
- addr_valid_out  output  1  request valid; held until data_valid_in.
- data_in  input  8  returned byte.
- data_valid_in  input  1  data_in valid; sampled on any clk_in edge.
- sprite_buffer_out  output  18 x 10 (unpacked [9:0])  entry = {X[7:0], oam_index[5:0], row[3:0]}.
- sprite_count_out  output  4  valid entries, 0..10; entries at index >= count are 18'h0.
- busy_out  output  1  scan in progress.
- done_out  output  1  one-clk pulse when scan ends.

Behaviour:
- Reset (also mid-scan): state IDLE, all buffer entries 0, count 0, addr_out 0, addr_valid_out 0, busy_out 0, done_out 0. Any pending memory response is dropped.
- IDLE:
  - start_in && tclk_in: latch LY and height (8 or 16).
  - Clear buffer and count.
  - Set idx=0, busy_out=1, go REQ_Y.
- start_in while busy is ignored.
- REQ_Y:
  - On a tclk_in edge, drive addr_out = OAM_BASE + 4*idx and addr_valid_out=1, go WAIT_Y.
  - Address arithmetic is 16-bit, no wrap for idx < 40.
- WAIT_Y:
  - On data_valid_in: addr_valid_out=0.
  - Compute d = {1'b0,LY}+9'd16 - {1'b0,Y} in 9 bits.
  - Hit iff {1'b0,LY}+16 >= Y and d < height.
  - Hit: store Y-derived row = d[3:0], go REQ_X.
  - Miss: go NEXT.
  - Y=0 never hits. Y>=160 hits only near the bottom lines and is handled by the same arithmetic.
- REQ_X: on a tclk_in edge, drive addr_out = OAM_BASE + 4*idx + 1 and addr_valid_out=1, go WAIT_X.
- WAIT_X:
  - On data_valid_in: addr_valid_out=0.
  - Write {data_in, idx[5:0], row} into slot[count], count++, go NEXT.
  - X is stored raw, including 0 and >=168; the consumer decides visibility.
- NEXT:
  - If count==MAX_SPRITES or idx==NUM_OAM_ENTRIES-1, go DONE.
  - Else idx++, go REQ_Y.
  - Early termination at 10 hits is intended; later entries are never read.
- DONE: done_out=1 for one clk, busy_out=0, go IDLE. Buffer and count hold until the next start or reset.
- Priority: lower OAM index always occupies the lower slot.
- Latency:
  - With memory responding on the clk after the request, each miss costs 1 request T-cycle plus the response, and each hit costs 2 requests.
  - The number of clk cycles depends on the tclk_in spacing.
- addr_out holds its last value while addr_valid_out=0.

Decomposition:
- ppu_pkg holds:
  - typedef sprite_entry_t (packed 18-bit struct: x, oam_index, row);
  - OAM_BASE, NUM_OAM_ENTRIES, MAX_SPRITES constants;
  - scanner state enum (IDLE, REQ_Y, WAIT_Y, REQ_X, WAIT_X, NEXT, DONE).
- One combinational sub-module, oam_y_match (inputs LY, Y, tall; outputs hit, row[3:0]), shared with the future sprite fetcher for row recompute.

Test Plan:
- Reset mid-scan (after 5 entries) -> next clk: count=0, buffer all zero, addr_valid_out=0, busy_out=0; a late data_valid_in is ignored.
- LY=0, 8-px, entry 3 Y=16 X=40, entry 7 Y=9 X=8, all others Y=0 -> count=2; slot0={8'd40,6'd3,4'd0}; slot1={8'd8,6'd7,4'd7}; X reads only for indices 3 and 7.
- LY=20, 16-px, entry 0 Y=21, entry 1 Y=37 -> entry0 row=15 hit; entry1 d=-1 miss; count=1.
- Same stimulus in 8-px mode -> entry0 d=15 >= 8 miss, count=0, done_out pulses after exactly 40 Y reads.
- All 40 entries hit (Y=16, LY=0) -> count=10, indices 0..9 in slots 0..9; last address read is 16'hFE25; done_out follows; addresses >= FE28 are never issued.
- Memory stalls data_valid_in for 7 clks -> addr_valid_out and addr_out stay stable throughout; start_in pulsed during busy -> ignored.
